// File: rtl/count_seq_pkg.sv
// rtl/count_seq_pkg.sv - shared types and defaults for the count sequencer
// Contents:
//   STATE_W        width of the sequencer state encoding
//   DEF_W          default counter/limit width
//   DEF_PRESCALE_W default prescale field width (COUNT_SEQ_PRESCALE_EN builds)
//   state_t        IDLE / LOAD / RUN / PAUSE
package count_seq_pkg;
  localparam int STATE_W        = 2;
  localparam int DEF_W          = 4;
  localparam int DEF_PRESCALE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;
endpackage

// File: rtl/count_seq_prescaler.sv
// rtl/count_seq_prescaler.sv - tick divider for the count sequencer
// Built only when COUNT_SEQ_PRESCALE_EN is defined.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   clear       return the divider to 0 (sequencer LOAD cycle)
//   enable      advance the divider this cycle; low freezes it
//   value       divide ratio minus one: tick every value+1 enabled clocks
//   tick        high on the enabled cycle where the divider wraps
`ifdef COUNT_SEQ_PRESCALE_EN
module count_seq_prescaler #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [PW-1:0] value,
  output logic          tick
);
  logic [PW-1:0] cnt;

  assign tick = enable && (cnt == value);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end
endmodule
`endif

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - control FSM and up-counter for a load/run/pause/stop sequence
// Optional feature macro: COUNT_SEQ_PRESCALE_EN (adds prescale port and tick divider).
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start        begin a run (IDLE only); stop aborts and wins over start/pause
//   pause        level; holds the count while high
//   auto_reload  1 = periodic, 0 = one-shot; captured at start
//   load_val     terminal value L; captured at start
//   prescale     tick every prescale+1 clocks (macro builds only)
//   count        current count
//   busy         high in LOAD/RUN/PAUSE
//   done         one-cycle pulse after the count reaches L
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int W = DEF_W
`ifdef COUNT_SEQ_PRESCALE_EN
  ,
  parameter int PRESCALE_W = DEF_PRESCALE_W
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  auto_reload,
  input  logic [W-1:0]          load_val,
`ifdef COUNT_SEQ_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [W-1:0]          count,
  output logic                  busy,
  output logic                  done
);
  state_t       state;
  logic [W-1:0] limit;
  logic         mode;
  logic         advance;
  logic         tick;

  // Counting proceeds in RUN, and also on the edge that leaves PAUSE, so a
  // pause costs exactly one tick per cycle that pause was sampled high.
  assign advance = ((state == RUN) || (state == PAUSE)) && !pause && !stop;

`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_q <= '0;
    end else if (state == IDLE && start && !stop) begin
      prescale_q <= prescale;
    end
  end

  count_seq_prescaler #(.PW(PRESCALE_W)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == LOAD),
    .enable (advance),
    .value  (prescale_q),
    .tick   (tick)
  );
`else
  assign tick = advance;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      limit <= '0;
      mode  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= LOAD;
            limit <= load_val;
            mode  <= auto_reload;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= RUN;
          end
        end
        RUN, PAUSE: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (pause) begin
            state <= PAUSE;
          end else begin
            state <= RUN;
            if (tick) begin
              if (count != limit) begin
                count <= count + 1'b1;
              end else begin
                done <= 1'b1;
                if (mode) begin
                  count <= '0;
                end else begin
                  // one-shot: count holds at L in IDLE
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - self-checking bench for count_sequencer
module tb_count_sequencer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, stop, pause, auto_reload;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         busy, done;
  int           ps_in = 0;
`ifdef COUNT_SEQ_PRESCALE_EN
  logic [3:0]   prescale;
  assign prescale = ps_in[3:0];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural reference: an active run either waits its load cycle or
  // consumes one tick per unpaused cycle
  bit           m_active, m_loading, m_mode, m_done;
  logic [W-1:0] m_count, m_limit;
  int           m_ps, m_pc;

  always #5 clk = ~clk;

  count_sequencer #(.W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .auto_reload (auto_reload),
    .load_val    (load_val),
`ifdef COUNT_SEQ_PRESCALE_EN
    .prescale    (prescale),
`endif
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_loading = 0; m_mode = 0; m_done = 0;
    m_count = '0; m_limit = '0; m_ps = 0; m_pc = 0;
  endtask

  task automatic model_edge();
    m_done = 0;
    if (!m_active) begin
      if (start && !stop) begin
        m_active = 1; m_loading = 1; m_count = '0;
        m_limit = load_val; m_mode = auto_reload; m_ps = ps_in;
      end
    end else if (stop) begin
      m_active = 0;
    end else if (m_loading) begin
      m_loading = 0; m_pc = 0;
    end else if (!pause) begin
      if (m_pc != m_ps) begin
        m_pc++;
      end else begin
        m_pc = 0;
        if (m_count == m_limit) begin
          m_done = 1;
          if (m_mode) m_count = '0;
          else m_active = 0;
        end else begin
          m_count = m_count + 1'b1;
        end
      end
    end
  endtask

  // one clock edge: sample #1 after it, advance the model, compare everything
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".busy"},  32'(busy),  32'(m_active));
    check({tag, ".done"},  32'(done),  32'(m_done));
  endtask

  task automatic quiet();
    start = 0; stop = 0; pause = 0;
  endtask

  initial begin
    reset = 1; quiet(); auto_reload = 0; load_val = '0;
    model_reset();
    #12;
    check("rst.count", 32'(count), 0);
    check("rst.busy",  32'(busy),  0);
    check("rst.done",  32'(done),  0);
    reset = 0;
    step("idle");

    // 1: one-shot L=5, done after edge 7 only
    load_val = 5; auto_reload = 0; start = 1;
    step("t1.start");
    start = 0;
    for (int e = 1; e <= 8; e++) begin
      step("t1.run");
      if (e <= 6) check("t1.count_seq", 32'(count), 32'(e - 1));
      check("t1.done_edge", 32'(done), 32'(e == 7));
      if (e >= 7) check("t1.busy_low", 32'(busy), 0);
    end

    // 2: periodic L=3
    load_val = 3; auto_reload = 1; start = 1;
    step("t2.start");
    start = 0;
    for (int e = 1; e <= 12; e++) begin
      step("t2.run");
      check("t2.count_seq", 32'(count), 32'((e - 1) % 4));
      check("t2.done_seq",  32'(done),  32'(e >= 5 && (e - 1) % 4 == 0));
      check("t2.busy",      32'(busy),  1);
    end
    stop = 1;
    step("t2.stop");
    stop = 0;

    // 3: L=9 one-shot, pause for 3 cycles at count=4
    load_val = 9; auto_reload = 0; start = 1;
    step("t3.start");
    start = 0;
    for (int e = 1; e <= 15; e++) begin
      pause = (e >= 6 && e <= 8);
      step("t3.run");
      if (e >= 5 && e <= 8) check("t3.frozen", 32'(count), 4);
      check("t3.done_edge", 32'(done), 32'(e == 14));
    end
    pause = 0;

    // 4: start+stop together does nothing; stop at count 6 gives no done
    load_val = 7; auto_reload = 0; start = 1; stop = 1;
    step("t4.startstop");
    check("t4.no_run", 32'(busy), 0);
    stop = 0;
    step("t4.start");
    start = 0;
    for (int e = 1; e <= 7; e++) step("t4.run");
    check("t4.at6", 32'(count), 6);
    stop = 1;
    step("t4.stop");
    stop = 0;
    check("t4.held", 32'(count), 6);
    check("t4.nodone", 32'(done), 0);
    step("t4.idle");

    // 5: L=15 one-shot, start re-asserted mid-run is ignored
    load_val = 15; auto_reload = 0; start = 1;
    step("t5.start");
    start = 0;
    for (int e = 1; e <= 18; e++) begin
      start = (e == 5);
      step("t5.run");
      check("t5.done_edge", 32'(done), 32'(e == 17));
    end
    start = 0;
    check("t5.nowrap", 32'(count), 15);
    start = 1;
    step("t5.restart");
    start = 0;
    for (int e = 1; e <= 3; e++) step("t5.run2");
    check("t5.at2", 32'(count), 2);
    reset = 1;
    #1;
    model_reset();
    check("t5.rst_count", 32'(count), 0);
    check("t5.rst_busy",  32'(busy),  0);
    #2;
    reset = 0;
    step("t5.after_rst");

`ifdef COUNT_SEQ_PRESCALE_EN
    // 6: prescale=2, L=2 -> done 10 edges after start; L=0 -> done at edge 4
    ps_in = 2; load_val = 2; auto_reload = 0; start = 1;
    step("t6.start");
    start = 0;
    for (int e = 1; e <= 11; e++) begin
      step("t6.run");
      check("t6.done_edge", 32'(done), 32'(e == 10));
    end
    load_val = 0; start = 1;
    step("t6.start0");
    start = 0;
    for (int e = 1; e <= 5; e++) begin
      step("t6.run0");
      check("t6.done_edge0", 32'(done), 32'(e == 4));
    end
`endif

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      start       = ($urandom_range(3) == 0);
      stop        = ($urandom_range(24) == 0);
      pause       = ($urandom_range(5) == 0);
      auto_reload = $urandom_range(1);
      load_val    = ($urandom_range(1) == 0) ? W'($urandom_range(2)) : W'($urandom);
`ifdef COUNT_SEQ_PRESCALE_EN
      ps_in       = $urandom_range(2);
`endif
      step("rand");
    end
    quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
